rf_wb_arbiter: RTL

- Shares the register file's single write port between two requesters: the pipeline writeback stage and the multi-cycle multiply/divide unit (MDU).
- Pipeline writes take priority. MDU results wait in a small FIFO and drain into idle writeback slots.
- Preserves write-after-write order by killing stale queued writes, and reports pending destinations to the hazard unit.
- Sits between the WB stage/MDU and the register file's RegWrite/RDaddr/RDdata inputs.

---
 rtl/rf_wb_arbiter_if.sv | 45 ++++
 rtl/rf_wb_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter_if
// Description : Bundle of the WB-stage, MDU, hazard-lookup and register-file
//               write-port signals around the writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_wb_arbiter_if;
   logic        pipe_we_i;
   logic [4:0]  pipe_addr_i;
   logic [31:0] pipe_data_i;
   logic        mdu_valid_i;
   logic [4:0]  mdu_addr_i;
   logic [31:0] mdu_data_i;
   logic        mdu_ready_o;
   logic [4:0]  rs_addr_i;
   logic [4:0]  rt_addr_i;
   logic        rs_pend_o;
   logic        rt_pend_o;
   logic        stall_o;
   logic        rf_we_o;
   logic [4:0]  rf_addr_o;
   logic [31:0] rf_data_o;

   // Arbiter side
   modport slave (
      input  pipe_we_i, pipe_addr_i, pipe_data_i,
      input  mdu_valid_i, mdu_addr_i, mdu_data_i,
      output mdu_ready_o,
      input  rs_addr_i, rt_addr_i,
      output rs_pend_o, rt_pend_o, stall_o,
      output rf_we_o, rf_addr_o, rf_data_o
   );

   // Pipeline / MDU / register-file side
   modport master (
      output pipe_we_i, pipe_addr_i, pipe_data_i,
      output mdu_valid_i, mdu_addr_i, mdu_data_i,
      input  mdu_ready_o,
      output rs_addr_i, rt_addr_i,
      input  rs_pend_o, rt_pend_o, stall_o,
      input  rf_we_o, rf_addr_o, rf_data_o
   );
endinterface
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Shares the register-file write port between the pipeline WB
//               stage (priority) and a FIFO of MDU results. Kills stale queued
//               writes for WAW ordering, reports pending destinations and
//               raises a one-cycle stall when the FIFO starves.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   rf_wb_arbiter_if.slave   bus
);

   localparam int c_PW = $clog2(DEPTH);
   localparam int c_CW = $clog2(DEPTH + 1);
   localparam int c_SW = $clog2(STARVE_MAX + 1);

   logic [4:0]       r_addr [DEPTH];
   logic [31:0]      r_data [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] r_kill;
   logic [c_PW-1:0]  r_wr_ptr;
   logic [c_PW-1:0]  r_rd_ptr;
   logic [c_CW-1:0]  r_count;
   logic [c_SW-1:0]  r_starve;
   logic             r_stall;
   logic             r_rf_we;
   logic [4:0]       r_rf_addr;
   logic [31:0]      r_rf_data;

   logic             w_full;
   logic             w_empty;
   logic             w_pipe_win;
   logic             w_pop;
   logic             w_push;
   logic             w_push_kill;
   logic             w_rs_hit;
   logic             w_rt_hit;
   logic [c_SW-1:0]  w_starve_inc;

   assign w_full       = (r_count == c_CW'(DEPTH));
   assign w_empty      = (r_count == '0);
   // While stalled the pipeline request is ignored; it is re-presented next cycle.
   assign w_pipe_win   = bus.pipe_we_i && !r_stall;
   assign w_pop        = !w_pipe_win && !w_empty;
   // Readiness uses the pre-pop full flag, so no push when full even if popping.
   assign w_push       = bus.mdu_valid_i && !w_full;
   // r0 results and results overtaken by a same-cycle pipe write enter dead.
   assign w_push_kill  = (bus.mdu_addr_i == 5'd0) ||
                         (w_pipe_win && (bus.mdu_addr_i == bus.pipe_addr_i));
   assign w_starve_inc = r_starve + c_SW'(1);

   assign bus.mdu_ready_o = !w_full;
   assign bus.stall_o     = r_stall;
   assign bus.rf_we_o     = r_rf_we;
   assign bus.rf_addr_o   = r_rf_addr;
   assign bus.rf_data_o   = r_rf_data;
   assign bus.rs_pend_o   = w_rs_hit && (bus.rs_addr_i != 5'd0);
   assign bus.rt_pend_o   = w_rt_hit && (bus.rt_addr_i != 5'd0);

   // Pending lookup: any live, non-killed entry matching the decode addresses.
   always_comb begin
      w_rs_hit = 1'b0;
      w_rt_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[i] && !r_kill[i] && (r_addr[i] == bus.rs_addr_i)) w_rs_hit = 1'b1;
         if (r_valid[i] && !r_kill[i] && (r_addr[i] == bus.rt_addr_i)) w_rt_hit = 1'b1;
      end
   end

   // FIFO payload storage; only meaningful where r_valid is set.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_addr[r_wr_ptr] <= bus.mdu_addr_i;
         r_data[r_wr_ptr] <= bus.mdu_data_i;
      end
   end

   // FIFO control: pointers, occupancy, per-entry valid and kill flags.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= '0;
         r_kill   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CW'(1);
            2'b01:   r_count <= r_count - c_CW'(1);
            default: r_count <= r_count;
         endcase
         for (int i = 0; i < DEPTH; i++) begin
            if (w_push && (r_wr_ptr == c_PW'(i))) begin
               r_valid[i] <= 1'b1;
               r_kill[i]  <= w_push_kill;
            end else if (w_pop && (r_rd_ptr == c_PW'(i))) begin
               r_valid[i] <= 1'b0;
               r_kill[i]  <= 1'b0;
            end else if (w_pipe_win && r_valid[i] && (r_addr[i] == bus.pipe_addr_i)) begin
               r_kill[i]  <= 1'b1;
            end
         end
      end
   end

   // Registered write-port arbitration plus starvation counter and stall pulse.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rf_we   <= 1'b0;
         r_rf_addr <= '0;
         r_rf_data <= '0;
         r_starve  <= '0;
         r_stall   <= 1'b0;
      end else begin
         if (w_pipe_win) begin
            r_rf_we   <= (bus.pipe_addr_i != 5'd0);
            r_rf_addr <= bus.pipe_addr_i;
            r_rf_data <= bus.pipe_data_i;
         end else if (w_pop) begin
            r_rf_we   <= !r_kill[r_rd_ptr] && (r_addr[r_rd_ptr] != 5'd0);
            r_rf_addr <= r_addr[r_rd_ptr];
            r_rf_data <= r_data[r_rd_ptr];
         end else begin
            r_rf_we   <= 1'b0;
         end

         // Non-empty and not popping means the pipeline beat the FIFO.
         if (w_empty || w_pop) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
         end else if (w_starve_inc == c_SW'(STARVE_MAX)) begin
            r_starve <= '0;
            r_stall  <= 1'b1;
         end else begin
            r_starve <= w_starve_inc;
            r_stall  <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
